vdp_cpu_port: RTL

CPU-side access controller for the VDP: decodes Z80 control-port and data-port accesses into VRAM writes, read-ahead fetches, VDP register writes and CRAM writes. It drives the 14-bit, 8-bit-wide CPU port of the dual-port VRAM, whose reads are synchronous with one cycle of latency. The video fetch port is untouched. It sits between the I/O decode wrapper and the VRAM, VDP register file and palette RAM.

---
 rtl/vdp_cpu_port.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU-side access controller for the VDP.
// Decodes Z80 control/data port strobes into VRAM writes, read-ahead
// prefetches, VDP register writes and CRAM writes. Drives the CPU port of
// the dual-port VRAM (synchronous read, one cycle latency).
module vdp_cpu_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_wr,
  input  logic        ctrl_rd,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [7:0]  cpu_wrdata,
  output logic [7:0]  cpu_rddata,
  output logic        busy,
  input  logic [7:0]  status_in,
  output logic        status_rd,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rddata,
  output logic        reg_wr,
  output logic [3:0]  reg_idx,
  output logic [7:0]  reg_data,
  output logic        cram_wr,
  output logic [4:0]  cram_addr,
  output logic [7:0]  cram_wrdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PF_ADDR  = 2'd1,
    PF_LATCH = 2'd2
  } pf_state_t;

  // Code values carried in the top two bits of the second control byte.
  localparam logic [1:0] CODE_VRAM_RD = 2'd0;
  localparam logic [1:0] CODE_REG_WR  = 2'd2;
  localparam logic [1:0] CODE_CRAM_WR = 2'd3;

  pf_state_t   state_r;
  logic [13:0] addr_r;
  logic [1:0]  code_r;
  logic        first_r;
  logic [7:0]  latch_r;
  logic [7:0]  buffer_r;
  logic        busy_r;
  // A data write increments addr one cycle late so the write pulse still
  // sees the original address on vram_addr.
  logic        inc_pend_r;

  logic        take_cw_s;
  logic        take_dw_s;
  logic        take_dr_s;
  logic        take_cr_s;
  logic        second_byte_s;
  logic        start_pf_s;
  logic        reg_hit_s;
  logic [13:0] addr_base_s;

  // Strobe arbitration: one strobe per cycle in fixed priority, none while busy.
  always_comb begin
    take_cw_s = 1'b0;
    take_dw_s = 1'b0;
    take_dr_s = 1'b0;
    take_cr_s = 1'b0;
    if (!busy_r) begin
      take_cw_s = ctrl_wr;
      take_dw_s = data_wr & ~ctrl_wr;
      take_dr_s = data_rd & ~ctrl_wr & ~data_wr;
      take_cr_s = ctrl_rd & ~ctrl_wr & ~data_wr & ~data_rd;
    end else begin
      take_cw_s = 1'b0;
      take_dw_s = 1'b0;
      take_dr_s = 1'b0;
      take_cr_s = 1'b0;
    end
  end

  // Effective address this cycle (pending post-write increment applied) and
  // derived command decodes.
  always_comb begin
    addr_base_s = addr_r;
    if (inc_pend_r) begin
      addr_base_s = addr_r + 14'd1;
    end else begin
      addr_base_s = addr_r;
    end
    second_byte_s = take_cw_s & first_r;
    start_pf_s    = take_dr_s | (second_byte_s & (cpu_wrdata[7:6] == CODE_VRAM_RD));
    reg_hit_s     = second_byte_s & (cpu_wrdata[7:6] == CODE_REG_WR);
  end

  // Address/code/latch state, read-ahead buffer and prefetch FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_r     <= 14'd0;
      code_r     <= 2'd0;
      first_r    <= 1'b0;
      latch_r    <= 8'd0;
      buffer_r   <= 8'd0;
      busy_r     <= 1'b0;
      inc_pend_r <= 1'b0;
    end else begin
      addr_r     <= addr_base_s;
      inc_pend_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start_pf_s) begin
            state_r <= PF_ADDR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        PF_ADDR: begin
          state_r <= PF_LATCH;
          busy_r  <= 1'b1;
        end
        PF_LATCH: begin
          buffer_r <= vram_rddata;
          addr_r   <= addr_base_s + 14'd1;
          state_r  <= IDLE;
          busy_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase

      if (take_cw_s) begin
        if (!first_r) begin
          latch_r <= cpu_wrdata;
          addr_r  <= {addr_base_s[13:8], cpu_wrdata};
          first_r <= 1'b1;
        end else begin
          addr_r  <= {cpu_wrdata[5:0], addr_base_s[7:0]};
          code_r  <= cpu_wrdata[7:6];
          first_r <= 1'b0;
        end
      end else if (take_dw_s) begin
        buffer_r   <= cpu_wrdata;
        inc_pend_r <= 1'b1;
        first_r    <= 1'b0;
      end else if (take_dr_s || take_cr_s) begin
        first_r <= 1'b0;
      end else begin
        first_r <= first_r;
      end
    end
  end

  // Registered write/status pulses, their captured data, and read results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_wren   <= 1'b0;
      vram_wrdata <= 8'd0;
      cram_wr     <= 1'b0;
      cram_addr   <= 5'd0;
      cram_wrdata <= 8'd0;
      reg_wr      <= 1'b0;
      reg_idx     <= 4'd0;
      reg_data    <= 8'd0;
      status_rd   <= 1'b0;
      cpu_rddata  <= 8'd0;
    end else begin
      vram_wren <= take_dw_s & (code_r != CODE_CRAM_WR);
      cram_wr   <= take_dw_s & (code_r == CODE_CRAM_WR);
      reg_wr    <= reg_hit_s;
      status_rd <= take_cr_s;

      if (take_dw_s) begin
        if (code_r == CODE_CRAM_WR) begin
          cram_addr   <= addr_base_s[4:0];
          cram_wrdata <= cpu_wrdata;
        end else begin
          vram_wrdata <= cpu_wrdata;
        end
      end

      if (reg_hit_s) begin
        reg_idx  <= cpu_wrdata[3:0];
        reg_data <= latch_r;
      end

      if (take_dr_s) begin
        cpu_rddata <= buffer_r;
      end else if (take_cr_s) begin
        cpu_rddata <= status_in;
      end
    end
  end

  assign vram_addr = addr_r;
  assign busy      = busy_r;

endmodule
